// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for the shared ARM/RISC-V fetch stage.
// Produces the fetch/decode stall and flush controls, the one-hot-priority
// PC redirect select, and a Busy flag covering the post-reset boot window
// and the wait for an in-flight ARM PC write to reach Writeback.
// Optional performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       RVPCSrcE,
  input  logic       LdStallD,
  output logic [1:0] PCSelF,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE,
  output logic       Busy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] PerfStallCnt,
  output logic [CNT_W-1:0] PerfRedirCnt,
  output logic [CNT_W-1:0] PerfLdStallCnt
`endif
);

  // Boot counter only needs to hold BOOT_CYCLES-1.
  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);
  localparam logic [BW-1:0] BOOT_ONE  = BW'(1);

  // PC mux select encodings.
  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_RESULT = 2'd1;
  localparam logic [1:0] SEL_ALU    = 2'd2;
  localparam logic [1:0] SEL_TARGET = 2'd3;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    PCWAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] boot_cnt;
  logic [BW-1:0] boot_cnt_next;

  logic       rd_w;
  logic       rd_b;
  logic       rd_r;
  logic       pending;
  logic [1:0] redir_sel;

  // The counter width is meaningless without the performance counters.
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  // Redirect qualification: ARM sources only count in ARM mode and vice versa.
  assign rd_w    = arm & PCSrcW;
  assign rd_b    = arm & BranchTakenE;
  assign rd_r    = ~arm & RVPCSrcE;
  assign pending = arm & (PCSrcD | PCSrcE | PCSrcM);

  // Redirect priority: RISC-V target, then ARM branch, then ARM PC write.
  always_comb begin
    redir_sel = SEL_PC4;
    if (rd_r) begin
      redir_sel = SEL_TARGET;
    end else if (rd_b) begin
      redir_sel = SEL_ALU;
    end else if (rd_w) begin
      redir_sel = SEL_RESULT;
    end
  end

  // State and boot counter; reset reloads the boot window from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      boot_cnt <= BOOT_INIT;
    end else begin
      state    <= state_next;
      boot_cnt <= boot_cnt_next;
    end
  end

  // Next-state and control outputs; reset forces the boot-style controls.
  always_comb begin
    state_next    = state;
    boot_cnt_next = boot_cnt;
    PCSelF        = SEL_PC4;
    StallF        = 1'b0;
    StallD        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    case (state)
      BOOT: begin
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = 1'b1;
        if (boot_cnt == '0) begin
          state_next = RUN;
        end else begin
          boot_cnt_next = boot_cnt - BOOT_ONE;
        end
      end
      RUN: begin
        PCSelF = redir_sel;
        if (rd_b || rd_r) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (pending) begin
          StallF     = 1'b1;
          FlushD     = 1'b1;
          state_next = PCWAIT;
        end else if (LdStallD) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      PCWAIT: begin
        PCSelF = redir_sel;
        StallF = 1'b1;
        FlushD = 1'b1;
        FlushE = LdStallD;
        if (rd_b || rd_r) begin
          StallF     = 1'b0;
          FlushE     = 1'b1;
          state_next = RUN;
        end else if (rd_w) begin
          StallF     = 1'b0;
          state_next = RUN;
        end else if (!arm) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next    = BOOT;
        boot_cnt_next = BOOT_INIT;
        StallF        = 1'b1;
        FlushD        = 1'b1;
        FlushE        = 1'b1;
      end
    endcase
    if (rst) begin
      PCSelF = SEL_PC4;
      StallF = 1'b1;
      StallD = 1'b0;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign Busy = rst | (state != RUN);

`ifdef FETCH_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic stall_evt;
  logic redir_evt;
  logic ld_evt;

  assign stall_evt = StallF & ((state == RUN) | (state == PCWAIT));
  assign redir_evt = (PCSelF != SEL_PC4);
  assign ld_evt    = (state == RUN) & ~rd_b & ~rd_r & ~pending & LdStallD;

  // Saturating event counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      PerfStallCnt   <= '0;
      PerfRedirCnt   <= '0;
      PerfLdStallCnt <= '0;
    end else begin
      if (stall_evt && (PerfStallCnt != '1)) begin
        PerfStallCnt <= PerfStallCnt + CNT_ONE;
      end
      if (redir_evt && (PerfRedirCnt != '1)) begin
        PerfRedirCnt <= PerfRedirCnt + CNT_ONE;
      end
      if (ld_evt && (PerfLdStallCnt != '1)) begin
        PerfLdStallCnt <= PerfLdStallCnt + CNT_ONE;
      end
    end
  end
`endif

endmodule
